sp1_div: RTL and testbench

SP1_DIV -- requirements
Module: sp1_div

---
 rtl/sp1_div.sv | 154 +++++++++++++++
 tb/tb_sp1_div.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sp1_div.sv
// Unsigned restoring divider: one shift-subtract step per clock, MSB first.
// sp1_sub supplies the trial subtraction and sp1_incr the step counter.

module sp1_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end
endmodule

module sp1_incr #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = a + W'(1);
endmodule

module sp1_div #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quo,
  output logic [DW-1:0] rem,
  output logic          dz
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] pr_reg, pr_next;     // partial remainder
  logic [DW-1:0] qd_reg, qd_next;     // dividend bits out at MSB, quotient bits in at LSB
  logic [DW-1:0] dvs_reg, dvs_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [DW-1:0] quo_reg, quo_next;
  logic [DW-1:0] rem_reg, rem_next;
  logic          dz_reg, dz_next;

  logic [DW:0]   shifted;
  logic [DW:0]   diff;
  logic          borrow;
  logic          restore;
  logic [DW:0]   step_rem;
  logic [DW-1:0] step_quo;
  logic [CW-1:0] cnt_inc;

  assign shifted = {pr_reg, qd_reg[DW-1]};

  sp1_sub #(.W(DW + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs_reg}),
    .diff   (diff),
    .borrow (borrow)
  );

  sp1_incr #(.W(CW)) u_incr (
    .a (cnt_reg),
    .y (cnt_inc)
  );

  // diff[DW] can only be set together with a borrow; folding it in keeps the
  // restore decision driven by every bit of the trial difference.
  assign restore  = borrow | diff[DW];
  assign step_rem = restore ? shifted : diff;
  assign step_quo = {qd_reg[DW-2:0], ~restore};

  always_comb begin
    state_next = state_reg;
    pr_next    = pr_reg;
    qd_next    = qd_reg;
    dvs_next   = dvs_reg;
    cnt_next   = cnt_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dz_next    = dz_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          pr_next  = '0;
          qd_next  = dividend;
          dvs_next = divisor;
          cnt_next = '0;
          if (divisor == '0) begin
            state_next = DONE;
            quo_next   = '1;
            rem_next   = dividend;
            dz_next    = 1'b1;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        pr_next  = step_rem[DW-1:0];
        qd_next  = step_quo;
        cnt_next = cnt_inc;
        if (cnt_reg == CW'(DW - 1)) begin
          state_next = DONE;
          quo_next   = step_quo;
          rem_next   = step_rem[DW-1:0];
          dz_next    = 1'b0;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pr_reg    <= '0;
      qd_reg    <= '0;
      dvs_reg   <= '0;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      pr_reg    <= pr_next;
      qd_reg    <= qd_next;
      dvs_reg   <= dvs_next;
      cnt_reg   <= cnt_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      dz_reg    <= dz_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign quo  = quo_reg;
  assign rem  = rem_reg;
  assign dz   = dz_reg;
endmodule

// File: tb/tb_sp1_div.sv
// Bench for sp1_div: cycle-level arithmetic reference model plus directed
// literal cases and a long held-start random run.
`timescale 1ns/1ps

module tb_sp1_div;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quo;
  logic [DW-1:0] rem;
  logic          dz;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int done_cyc_q[$];

  // reference model state: cycles of busy left, visible results, pending results
  int            m_left = 0;
  logic [DW-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic          m_dz = 1'b0, p_dz = 1'b0;

  sp1_div #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quo      (quo),
    .rem      (rem),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A nonzero divide is busy for DW+1 cycles (DW in CALC, one in DONE);
  // a zero divide goes straight to DONE for one cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_left = 0;
        m_q = '0; m_r = '0; m_dz = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 1) begin
          m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (start) begin
        if (divisor == '0) begin
          p_q = '1; p_r = dividend; p_dz = 1'b1;
          m_left = 1;
          m_q = p_q; m_r = p_r; m_dz = p_dz;
        end else begin
          p_q = dividend / divisor;
          p_r = dividend % divisor;
          p_dz = 1'b0;
          m_left = DW + 1;
        end
      end
      #1;
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_left == 1));
      chk("quo", 64'(quo), 64'(m_q));
      chk("rem", 64'(rem), 64'(m_r));
      chk("dz", 64'(dz), 64'(m_dz));
      if (done) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 300000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] eq, input logic [DW-1:0] er,
                        input logic edz, input bit poke, input string tag);
    int n;
    int nb;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    n = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (poke && n == 5) begin
        start = 1'b1; dividend = 32'd99; divisor = 32'd4;
      end else if (poke && n == 6) begin
        start = 1'b0;
      end
    end
    chk($sformatf("%s latency", tag), 64'(n), 64'((b == 0) ? 0 : DW));
    chk($sformatf("%s busy cycles", tag), 64'(nb), 64'((b == 0) ? 1 : DW + 1));
    chk($sformatf("%s quo", tag), 64'(quo), 64'(eq));
    chk($sformatf("%s rem", tag), 64'(rem), 64'(er));
    chk($sformatf("%s dz", tag), 64'(dz), 64'(edz));
    if (poke) begin
      start = 1'b1; dividend = 32'd11; divisor = 32'd2;
    end
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s done after", tag), 64'(done), 64'(0));
    chk($sformatf("%s busy after", tag), 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    chk($sformatf("%s done pulses", tag), 64'(done_cnt - d0), 64'(1));
    chk($sformatf("%s quo held", tag), 64'(quo), 64'(eq));
  endtask

  initial begin
    int n;
    int d0;
    int q0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset quo", 64'(quo), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, "100/7");
    run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "max/1");
    run_op(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0, "5/9");
    run_op(32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, "div0");
    run_op(32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 1'b0, "10/3");
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, "100/7 poked");

    // reset in the middle of a CALC run
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort quo", 64'(quo), 64'(0));
    chk("abort rem", 64'(rem), 64'(0));
    chk("abort dz", 64'(dz), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort done pulses", 64'(done_cnt - d0), 64'(0));
    run_op(32'd20, 32'd4, 32'd5, 32'd0, 1'b0, 1'b0, "20/4");

    // start held high for three operations
    d0 = done_cnt;
    q0 = done_cyc_q.size();
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    n = 0;
    while (done_cnt < d0 + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("held ops", 64'(done_cnt - d0), 64'(3));
    if (done_cyc_q.size() >= q0 + 3) begin
      chk("held spacing 1", 64'(done_cyc_q[q0+1] - done_cyc_q[q0]), 64'(DW + 2));
      chk("held spacing 2", 64'(done_cyc_q[q0+2] - done_cyc_q[q0+1]), 64'(DW + 2));
    end
    chk("held quo", 64'(quo), 64'(333));
    chk("held rem", 64'(rem), 64'(1));
    repeat (3) @(negedge clk);

    // random pairs with start held; operands churn every cycle
    d0 = done_cnt;
    start = 1'b1;
    n = 0;
    while (done_cnt < d0 + 1500 && n < 60000) begin
      case ($urandom_range(0, 7))
        0:       divisor = '0;
        1, 2:    divisor = DW'($urandom_range(1, 15));
        default: divisor = $urandom;
      endcase
      dividend = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("random ops completed", 64'(done_cnt - d0 >= 1500), 64'(1));
    repeat (DW + 4) @(negedge clk);
    chk("random idle", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
